// File: rtl/freq_div_seq_if.sv
// Bundled slot-table configuration, sequence control and divider outputs of freq_div_seq.
`timescale 1ns/1ps
interface freq_div_seq_if #(
    parameter int DIV_W = 16,
    parameter int REP_W = 8
);
    logic             cfg_we_i;
    logic [1:0]       cfg_addr_i;
    logic [DIV_W-1:0] cfg_div_i;
    logic [REP_W-1:0] cfg_rep_i;
    logic             start_i;
    logic             stop_i;
    logic             loop_i;
    logic             led_o;
    logic             tick_o;
    logic [1:0]       slot_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_div_i, cfg_rep_i, start_i, stop_i, loop_i,
        input  led_o, tick_o, slot_o, busy_o, done_o
    );

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_div_i, cfg_rep_i, start_i, stop_i, loop_i,
        output led_o, tick_o, slot_o, busy_o, done_o
    );
endinterface

// File: rtl/freq_div_seq.sv
// Four-slot frequency divider sequencer: each slot divides clk_i by its divisor
// for a programmed number of output periods, then hands over to the next slot.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; all outputs low except a one-cycle done
// S_LOAD | copy current slot {div, rep} to working registers; skip if div < 2
// S_RUN  | count cnt 0..div-1, tick on the last count, advance after rep ticks
`timescale 1ns/1ps
module freq_div_seq #(
    parameter int DIV_W = 16,
    parameter int REP_W = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    freq_div_seq_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    logic [DIV_W-1:0] tbl_div [4];
    logic [REP_W-1:0] tbl_rep [4];

    state_t           state, state_n;
    logic [1:0]       slot, slot_n;
    logic             done_q, done_n;
    logic [DIV_W-1:0] div_q, cnt_q;
    logic [REP_W-1:0] rep_q, repcnt_q, rep_last;

    logic             tick, last_tick, load_ok;
    state_t           adv_state;
    logic [1:0]       adv_slot;
    logic             adv_done;

    // div >= 2 guarantees div-1 never underflows; rep == 0 behaves as one period
    assign tick      = (state == S_RUN) && (cnt_q == div_q - DIV_W'(1));
    assign rep_last  = (rep_q == '0) ? '0 : rep_q - REP_W'(1);
    assign last_tick = tick && (repcnt_q == rep_last);
    assign load_ok   = tbl_div[slot] >= DIV_W'(2);

    // Where the sequence goes after the current slot finishes or is skipped
    always_comb begin
        adv_state = S_LOAD;
        adv_slot  = slot + 2'd1;
        adv_done  = 1'b0;
        if (slot == 2'd3) begin
            if (bus.loop_i) begin
                adv_slot = 2'd0;
            end else begin
                adv_state = S_IDLE;
                adv_slot  = slot;
                adv_done  = 1'b1;
            end
        end
    end

    // Next-state logic; stop overrides both start and any advance
    always_comb begin
        state_n = state;
        slot_n  = slot;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_i && !bus.stop_i) begin
                    state_n = S_LOAD;
                    slot_n  = 2'd0;
                end
            end
            S_LOAD: begin
                if (bus.stop_i) begin
                    state_n = S_IDLE;
                end else if (load_ok) begin
                    state_n = S_RUN;
                end else begin
                    state_n = adv_state;
                    slot_n  = adv_slot;
                    done_n  = adv_done;
                end
            end
            S_RUN: begin
                if (bus.stop_i) begin
                    state_n = S_IDLE;
                end else if (last_tick) begin
                    state_n = adv_state;
                    slot_n  = adv_slot;
                    done_n  = adv_done;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, slot index and completion pulse registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            slot   <= 2'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            slot   <= slot_n;
            done_q <= done_n;
        end
    end

    // Slot table; a write racing a LOAD of the same slot lands after the latch
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 4; i++) begin
                tbl_div[i] <= '0;
                tbl_rep[i] <= '0;
            end
        end else if (bus.cfg_we_i) begin
            tbl_div[bus.cfg_addr_i] <= bus.cfg_div_i;
            tbl_rep[bus.cfg_addr_i] <= bus.cfg_rep_i;
        end
    end

    // Working copy of the active slot plus period and repeat counters
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            div_q    <= '0;
            rep_q    <= '0;
            cnt_q    <= '0;
            repcnt_q <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    div_q    <= tbl_div[slot];
                    rep_q    <= tbl_rep[slot];
                    cnt_q    <= '0;
                    repcnt_q <= '0;
                end
                S_RUN: begin
                    if (bus.stop_i) begin
                        cnt_q <= '0;
                    end else if (tick) begin
                        cnt_q    <= '0;
                        repcnt_q <= repcnt_q + REP_W'(1);
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign bus.led_o  = (state == S_RUN) && (cnt_q >= (div_q >> 1));
    assign bus.tick_o = tick;
    assign bus.slot_o = slot;
    assign bus.busy_o = (state != S_IDLE);
    assign bus.done_o = done_q;

endmodule

// File: tb/tb_freq_div_seq.sv
// Directed self-checking bench for freq_div_seq: a vector table for the basic
// single-slot and odd-divisor sequences, then hand-written multi-cycle cases.
`timescale 1ns/1ps
module tb_freq_div_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    freq_div_seq_if #(.DIV_W(16), .REP_W(8)) bus ();

    freq_div_seq #(.DIV_W(16), .REP_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [15:0] div;
        logic [7:0]  rep;
        logic        start, stop, loop;
        logic        led, tick;
        logic [1:0]  slot;
        logic        busy, done;
    } vec_t;

    vec_t vt [40];
    int   nv = 0;

    task automatic add(input int we, input int addr, input int div, input int rep,
                       input int start, input int stop, input int loop,
                       input int led, input int tick, input int slot,
                       input int busy, input int done);
        vt[nv].we    = 1'(we);
        vt[nv].addr  = 2'(addr);
        vt[nv].div   = 16'(div);
        vt[nv].rep   = 8'(rep);
        vt[nv].start = 1'(start);
        vt[nv].stop  = 1'(stop);
        vt[nv].loop  = 1'(loop);
        vt[nv].led   = 1'(led);
        vt[nv].tick  = 1'(tick);
        vt[nv].slot  = 2'(slot);
        vt[nv].busy  = 1'(busy);
        vt[nv].done  = 1'(done);
        nv++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int led, input int tick,
                           input int slot, input int busy, input int done);
        chk({tag, " led"},  int'(bus.led_o),  led);
        chk({tag, " tick"}, int'(bus.tick_o), tick);
        chk({tag, " slot"}, int'(bus.slot_o), slot);
        chk({tag, " busy"}, int'(bus.busy_o), busy);
        chk({tag, " done"}, int'(bus.done_o), done);
    endtask

    task automatic idle_inputs();
        bus.cfg_we_i   = 1'b0;
        bus.cfg_addr_i = 2'd0;
        bus.cfg_div_i  = 16'd0;
        bus.cfg_rep_i  = 8'd0;
        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input int div, input int rep);
        bus.cfg_we_i   = 1'b1;
        bus.cfg_addr_i = 2'(addr);
        bus.cfg_div_i  = 16'(div);
        bus.cfg_rep_i  = 8'(rep);
        @(negedge clk);
        bus.cfg_we_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int slot_a [19] = '{0,0,0,1,2,2,2,2,3,0,0,0,1,2,2,2,2,3,3};

        idle_inputs();
        bus.loop_i = 1'b0;

        // single slot {4,2}: start at row 1, LOAD row 2, RUN rows 3..10
        add(1,0,4,2, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 1,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 1,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 1,0,0,1,0);
        add(0,0,0,0, 0,0,0, 1,1,0,1,0);
        add(0,0,0,0, 1,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 1,0,0,1,0);
        add(0,0,0,0, 0,0,0, 1,1,0,1,0);
        add(0,0,0,0, 0,0,0, 0,0,1,1,0);
        add(0,0,0,0, 0,0,0, 0,0,2,1,0);
        add(0,0,0,0, 0,0,0, 0,0,3,1,0);
        add(0,0,0,0, 0,0,0, 0,0,3,0,1);
        // odd divisor {5,1}
        add(1,0,5,1, 0,0,0, 0,0,3,0,0);
        add(0,0,0,0, 1,0,0, 0,0,3,0,0);
        add(0,0,0,0, 0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 1,0,0,1,0);
        add(0,0,0,0, 0,0,0, 1,0,0,1,0);
        add(0,0,0,0, 0,0,0, 1,1,0,1,0);
        add(0,0,0,0, 0,0,0, 0,0,1,1,0);
        add(0,0,0,0, 0,0,0, 0,0,2,1,0);
        add(0,0,0,0, 0,0,0, 0,0,3,1,0);
        add(0,0,0,0, 0,0,0, 0,0,3,0,1);
        // start together with stop in IDLE must not launch
        add(0,0,0,0, 1,1,0, 0,0,3,0,0);
        add(0,0,0,0, 0,0,0, 0,0,3,0,0);

        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < nv; i++) begin
            bus.cfg_we_i   = vt[i].we;
            bus.cfg_addr_i = vt[i].addr;
            bus.cfg_div_i  = vt[i].div;
            bus.cfg_rep_i  = vt[i].rep;
            bus.start_i    = vt[i].start;
            bus.stop_i     = vt[i].stop;
            bus.loop_i     = vt[i].loop;
            chk_all($sformatf("vec%0d", i), int'(vt[i].led), int'(vt[i].tick),
                    int'(vt[i].slot), int'(vt[i].busy), int'(vt[i].done));
            @(negedge clk);
        end
        idle_inputs();

        // loop through {2,1},-,{3,1},- and drop loop_i in the second pass
        cfg_write(0, 2, 1);
        cfg_write(1, 0, 0);
        cfg_write(2, 3, 1);
        cfg_write(3, 0, 0);
        bus.loop_i  = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            chk($sformatf("loop c%0d slot", c), int'(bus.slot_o), slot_a[c-1]);
            chk($sformatf("loop c%0d busy", c), int'(bus.busy_o), (c < 19) ? 1 : 0);
            chk($sformatf("loop c%0d done", c), int'(bus.done_o), (c == 19) ? 1 : 0);
            if (c == 3) chk("loop c3 led", int'(bus.led_o), 1);
            if (c == 15) bus.loop_i = 1'b0;
            @(negedge clk);
        end
        chk("loop after done", int'(bus.done_o), 0);

        // stop with start in the cnt=1 cycle of slot 0 (also its last tick)
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("stop c1 busy", int'(bus.busy_o), 1);
        @(negedge clk);
        chk("stop c2 led", int'(bus.led_o), 0);
        @(negedge clk);
        chk("stop c3 led", int'(bus.led_o), 1);
        chk("stop c3 tick", int'(bus.tick_o), 1);
        bus.stop_i  = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.stop_i  = 1'b0;
        bus.start_i = 1'b0;
        chk_all("stop c4", 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("stop c5", 0, 0, 0, 0, 0);

        // shadowing: rewrite running slot 0, and race a write with its next LOAD
        cfg_write(0, 4, 3);
        cfg_write(2, 0, 0);
        bus.loop_i  = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            int e_led, e_tick, e_slot;
            e_tick = (c == 5 || c == 9 || c == 13 || c == 23) ? 1 : 0;
            if (c >= 2 && c <= 13)       e_led = (((c - 2) % 4) >= 2) ? 1 : 0;
            else if (c >= 21 && c <= 23) e_led = 1;
            else                         e_led = 0;
            if (c <= 13)      e_slot = 0;
            else if (c == 14) e_slot = 1;
            else if (c == 15) e_slot = 2;
            else if (c == 16) e_slot = 3;
            else if (c <= 23) e_slot = 0;
            else if (c == 24) e_slot = 1;
            else if (c == 25) e_slot = 2;
            else              e_slot = 3;
            chk_all($sformatf("shadow c%0d", c), e_led, e_tick, e_slot,
                    (c < 27) ? 1 : 0, (c == 27) ? 1 : 0);
            bus.cfg_we_i = 1'b0;
            if (c == 3) begin
                bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 2'd0;
                bus.cfg_div_i = 16'd6; bus.cfg_rep_i = 8'd1;
            end
            if (c == 17) begin
                bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 2'd0;
                bus.cfg_div_i = 16'd8; bus.cfg_rep_i = 8'd1;
            end
            if (c == 18) bus.loop_i = 1'b0;
            @(negedge clk);
        end
        idle_inputs();

        // reset mid-RUN, then an all-invalid table walks four LOADs and completes
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst pre busy", int'(bus.busy_o), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_all("rst after", 0, 0, 0, 0, 0);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk_all($sformatf("inval c%0d", c), 0, 0, (c <= 4) ? c - 1 : 3,
                    (c <= 4) ? 1 : 0, (c == 5) ? 1 : 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
